// File: rtl/elastic_pipeline_pkg.sv
// elastic_pipeline_pkg: shared types and helpers for the elastic pipeline.
// Stats counter width and occupancy width helper live here.
package elastic_pipeline_pkg;

    localparam int STATS_WIDTH = 32;

    typedef logic [STATS_WIDTH-1:0] stats_t;

    function automatic int occ_width(int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/elastic_pipeline_stage.sv
// pipe_stage: one valid/data register of the elastic pipeline.
// Data captures only on a load of valid data; clear drops valid only.
module pipe_stage #(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  clear,
    input  logic                  prev_valid,
    input  logic [DATA_WIDTH-1:0] prev_data,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data
);

    // Stage register: clear beats load; data held unless valid data arrives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= RESET_DATA;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= prev_valid;
            if (prev_valid) begin
                data <= prev_data;
            end
        end
    end

endmodule

// File: rtl/elastic_pipeline.sv
// elastic_pipeline: valid/ready delay line with bubble collapse and flush.
// Optional counters enabled by ELASTIC_PIPELINE_STATS_EN.
module elastic_pipeline
    import elastic_pipeline_pkg::*;
#(
    parameter int                    DATA_WIDTH      = 8,
    parameter int                    PIPELINE_LENGTH = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_DATA      = '0
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush,
    input  logic [DATA_WIDTH-1:0]                  in_data,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    output logic [DATA_WIDTH-1:0]                  out_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [occ_width(PIPELINE_LENGTH)-1:0]  occupancy
`ifdef ELASTIC_PIPELINE_STATS_EN
    ,
    output stats_t                                 stall_cycles,
    output stats_t                                 beats_out
`endif
);

    localparam int N     = PIPELINE_LENGTH;
    localparam int OCC_W = occ_width(PIPELINE_LENGTH);

    logic [N-1:0]          v;
    logic [N-1:0]          adv;
    logic [N-1:0]          load;
    logic [N-1:0]          prev_v;
    logic [DATA_WIDTH-1:0] d      [N];
    logic [DATA_WIDTH-1:0] prev_d [N];
    logic                  accept;
    logic                  xfer;

    // Advance chain: a stage moves when it is valid and the next slot frees
    always_comb begin
        adv        = '0;
        adv[N-1]   = v[N-1] & out_ready;
        for (int i = N - 2; i >= 0; i--) begin
            adv[i] = v[i] & (~v[i+1] | adv[i+1]);
        end
    end

    // Each stage's source: the input port for stage 0, else the predecessor
    always_comb begin
        prev_v    = '0;
        prev_v[0] = in_valid;
        prev_d[0] = in_data;
        for (int i = 1; i < N; i++) begin
            prev_v[i] = v[i-1];
            prev_d[i] = d[i-1];
        end
    end

    assign load      = ~v | adv;
    assign in_ready  = ~flush & load[0];
    assign accept    = in_valid & in_ready;
    assign out_valid = v[N-1];
    assign out_data  = d[N-1];
    assign xfer      = out_valid & out_ready;

    for (genvar i = 0; i < N; i++) begin : g_stage
        pipe_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .RESET_DATA (RESET_DATA)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .load       (load[i]),
            .clear      (flush),
            .prev_valid (prev_v[i]),
            .prev_data  (prev_d[i]),
            .valid      (v[i]),
            .data       (d[i])
        );
    end

    // Occupancy tracks accepts minus output transfers; flush empties it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else if (accept && !xfer) begin
            occupancy <= occupancy + OCC_W'(1);
        end else if (!accept && xfer) begin
            occupancy <= occupancy - OCC_W'(1);
        end
    end

`ifdef ELASTIC_PIPELINE_STATS_EN
    // Saturating stall and delivered-beat counters; flush leaves them alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            beats_out    <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + STATS_WIDTH'(1);
            end
            if (xfer && beats_out != '1) begin
                beats_out <= beats_out + STATS_WIDTH'(1);
            end
        end
    end
`endif

endmodule
